// File: rtl/wb_if.sv
// Wishbone classic-cycle bus bundle.
// Master drives the request, slave drives the response.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [DW/8-1:0] SEL;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, CYC, STB, WE, SEL, DAT_W,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CYC, STB, WE, SEL, DAT_W,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_target.sv
// Wishbone classic slave backed by a word-organised RAM.
// Programmable wait states, byte lanes, ERR on bad address.
module wb_sram_target #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] MEM_BASE = '0,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  s,
  output logic err_o
);
  localparam int AW  = WB_ADDR_WIDTH;
  localparam int DW  = WB_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = (MEM_DEPTH_WORDS > 1) ?
                       $clog2(MEM_DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  logic [DW-1:0] mem [MEM_DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic [NB-1:0] sel_q, sel_d;
  logic [DW-1:0] dw_q, dw_d;
  logic          hit_q, hit_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_r_q, dat_r_d;

  logic [AW-1:0] off;
  logic [AW-1:0] idx_all;
  logic [IW-1:0] idx_now;
  logic          hit_now;
  logic          req;

  logic          go_resp;
  logic          mem_we;
  logic [IW-1:0] acc_idx;
  logic          acc_we;
  logic [NB-1:0] acc_sel;
  logic [DW-1:0] acc_dw;
  logic          acc_hit;

  // Window and alignment decode of the live address.
  always_comb begin
    off     = s.ADR - MEM_BASE;
    idx_all = off >> LSB;
    idx_now = idx_all[IW-1:0];
    hit_now = (s.ADR >= MEM_BASE) &&
              (idx_all < AW'(MEM_DEPTH_WORDS)) &&
              ((off & AW'(NB - 1)) == '0);
    req     = s.CYC & s.STB;
  end

  // Next-state, request capture and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dw_d    = dw_q;
    hit_d   = hit_q;
    dat_r_d = dat_r_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    go_resp = 1'b0;
    mem_we  = 1'b0;
    acc_idx = idx_q;
    acc_we  = we_q;
    acc_sel = sel_q;
    acc_dw  = dw_q;
    acc_hit = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d = idx_now;
          we_d  = s.WE;
          sel_d = s.SEL;
          dw_d  = s.DAT_W;
          hit_d = hit_now;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            // Zero wait states: respond from live bus values.
            state_d = S_RESP;
            go_resp = 1'b1;
            acc_idx = idx_now;
            acc_we  = s.WE;
            acc_sel = s.SEL;
            acc_dw  = s.DAT_W;
            acc_hit = hit_now;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      if (acc_hit) begin
        ack_d = 1'b1;
        if (acc_we) mem_we = 1'b1;
        else        dat_r_d = mem[acc_idx];
      end else begin
        err_d   = 1'b1;
        dat_r_d = '0;
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dw_q    <= '0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dw_q    <= dw_d;
      hit_q   <= hit_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
    end
  end

  // Byte-lane RAM write on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dw[8*i +: 8];
      end
    end
  end

  assign s.ACK   = ack_q;
  assign s.ERR   = err_q;
  assign s.DAT_R = dat_r_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wb_sram_target.sv
// Directed plus random bench for wb_sram_target.
// Three instances cover 0, 1 and 3 wait states.
module tb_wb_sram_target;
  localparam int unsigned BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m_adr = '0;
  logic [31:0] m_dw  = '0;
  logic        m_we  = 1'b0;
  logic [3:0]  m_sel = '0;
  logic        m_cyc = 1'b0;
  logic        m_stb = 1'b0;
  int          dsel  = 0;

  logic        r_ack, r_err, r_erro;
  logic [31:0] r_dat;
  logic        eo0, eo1, eo3;

  wb_if #(.AW(32), .DW(32)) b0 ();
  wb_if #(.AW(32), .DW(32)) b1 ();
  wb_if #(.AW(32), .DW(32)) b3 ();

  assign b0.ADR = m_adr;  assign b1.ADR = m_adr;  assign b3.ADR = m_adr;
  assign b0.WE  = m_we;   assign b1.WE  = m_we;   assign b3.WE  = m_we;
  assign b0.SEL = m_sel;  assign b1.SEL = m_sel;  assign b3.SEL = m_sel;
  assign b0.DAT_W = m_dw; assign b1.DAT_W = m_dw; assign b3.DAT_W = m_dw;
  assign b0.CYC = m_cyc && dsel == 0;
  assign b1.CYC = m_cyc && dsel == 1;
  assign b3.CYC = m_cyc && dsel == 2;
  assign b0.STB = m_stb && dsel == 0;
  assign b1.STB = m_stb && dsel == 1;
  assign b3.STB = m_stb && dsel == 2;

  wb_sram_target #(
    .MEM_BASE(32'(BASE)), .MEM_DEPTH_WORDS(DEPTH),
    .WAIT_STATES(0)
  ) u0 (.clk(clk), .rst(rst), .s(b0), .err_o(eo0));

  wb_sram_target #(
    .MEM_BASE(32'(BASE)), .MEM_DEPTH_WORDS(DEPTH),
    .WAIT_STATES(1)
  ) u1 (.clk(clk), .rst(rst), .s(b1), .err_o(eo1));

  wb_sram_target #(
    .MEM_BASE(32'(BASE)), .MEM_DEPTH_WORDS(DEPTH),
    .WAIT_STATES(3)
  ) u3 (.clk(clk), .rst(rst), .s(b3), .err_o(eo3));

  always_comb begin
    r_ack  = 1'b0;
    r_err  = 1'b0;
    r_erro = 1'b0;
    r_dat  = '0;
    case (dsel)
      0: begin
        r_ack = b0.ACK; r_err = b0.ERR;
        r_erro = eo0; r_dat = b0.DAT_R;
      end
      1: begin
        r_ack = b1.ACK; r_err = b1.ERR;
        r_erro = eo1; r_dat = b1.DAT_R;
      end
      default: begin
        r_ack = b3.ACK; r_err = b3.ERR;
        r_erro = eo3; r_dat = b3.DAT_R;
      end
    endcase
  end

  // Reference memory: per-instance words plus per-byte known flags.
  logic [31:0] mdl [3][DEPTH];
  logic [3:0]  vld [3][DEPTH];

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] last_rdat;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic bit exp_hit(input logic [31:0] a);
    longint off;
    off = longint'({32'b0, a}) - longint'(BASE);
    return off >= 0 && off < 4 * longint'(DEPTH) && off % 4 == 0;
  endfunction

  task automatic xfer(input int d, input logic [31:0] a,
                      input logic w, input logic [3:0] sl,
                      input logic [31:0] wd);
    bit   hit;
    int   idx;
    int   n;
    hit = exp_hit(a);
    idx = hit ? int'((a - BASE) / 4) : 0;
    @(negedge clk);
    dsel = d; m_adr = a; m_we = w; m_sel = sl; m_dw = wd;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!(r_ack || r_err) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(ws_of(d)));
    chk("ack", 64'(r_ack), 64'(hit));
    chk("err", 64'(r_err), 64'(!hit));
    chk("err_o", 64'(r_erro), 64'(!hit));
    if (!hit) chk("err_dat", 64'(r_dat), 64'(0));
    else if (!w && vld[d][idx] == 4'hF)
      chk("rd_dat", 64'(r_dat), 64'(mdl[d][idx]));
    last_rdat = r_dat;
    m_cyc = 1'b0; m_stb = 1'b0;
    if (hit && w) begin
      for (int i = 0; i < 4; i++) begin
        if (sl[i]) begin
          mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
          vld[d][idx][i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("one_cycle", 64'({r_ack, r_err}), 64'(0));
  endtask

  task automatic b2b(input bit do_rst);
    int got;
    got = 0;
    @(negedge clk);
    dsel = 0; m_adr = BASE; m_we = 1'b0; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (do_rst && c >= 3) begin
        if (c == 3) begin
          rst = 1'b1;
          #1;
        end
        chk("rst_out",
            64'({r_ack, r_err, r_erro, r_dat}), 64'(0));
      end else begin
        chk("b2b_ack", 64'(r_ack), 64'(c % 2 == 0));
        if (r_ack && got < 4) begin
          chk("b2b_dat", 64'(r_dat), 64'(mdl[0][got]));
          got++;
          m_adr = BASE + 32'(4 * got);
          if (got == 4) begin
            m_cyc = 1'b0; m_stb = 1'b0;
          end
        end
      end
    end
    if (!do_rst) chk("b2b_cnt", 64'(got), 64'(4));
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    rst = 1'b0;
  endtask

  logic [31:0] a, wd;
  logic [31:0] old7;

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < int'(DEPTH); i++) begin
        mdl[d][i] = '0;
        vld[d][i] = '0;
      end

    // Reset state on all three instances.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u0", 64'({b0.ACK, b0.ERR, eo0, b0.DAT_R}), 64'(0));
    chk("rst_u1", 64'({b1.ACK, b1.ERR, eo1, b1.DAT_R}), 64'(0));
    chk("rst_u3", 64'({b3.ACK, b3.ERR, eo3, b3.DAT_R}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // First read after reset: latency only.
    xfer(1, BASE, 1'b0, 4'hF, '0);

    // Write / read-back.
    xfer(1, BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    xfer(1, BASE + 32'h10, 1'b0, 4'hF, '0);
    chk("wr_rd", 64'(last_rdat), 64'(32'hDEAD_BEEF));

    // Byte lanes.
    xfer(1, BASE + 32'h20, 1'b1, 4'hF, 32'h1122_3344);
    xfer(1, BASE + 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD);
    xfer(1, BASE + 32'h20, 1'b0, 4'hF, '0);
    chk("lanes", 64'(last_rdat), 64'(32'h11BB_33DD));
    xfer(1, BASE + 32'h24, 1'b1, 4'h0, 32'hFFFF_FFFF);

    // Window edges and misalignment.
    xfer(1, BASE + 4 * DEPTH, 1'b0, 4'hF, '0);
    xfer(1, BASE + 2, 1'b0, 4'hF, '0);
    xfer(1, BASE - 4, 1'b1, 4'hF, 32'h1234_5678);
    xfer(1, BASE + 4 * (DEPTH - 1), 1'b1, 4'hF, 32'hCAFE_0001);
    xfer(1, BASE + 4 * (DEPTH - 1), 1'b0, 4'hF, '0);

    // Abort during wait states leaves old data.
    old7 = 32'h0BAD_F00D;
    xfer(2, BASE + 28, 1'b1, 4'hF, old7);
    @(negedge clk);
    dsel = 2; m_adr = BASE + 28; m_we = 1'b1;
    m_sel = 4'hF; m_dw = 32'h5555_5555;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", 64'({r_ack, r_err}), 64'(0));
    end
    xfer(2, BASE + 28, 1'b0, 4'hF, '0);
    chk("abort_old", 64'(last_rdat), 64'(old7));

    // Random traffic against the model.
    for (int k = 0; k < 150; k++) begin
      int d;
      d = (k % 3 == 0) ? 0 : 1;
      case ($urandom_range(0, 9))
        0: a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
        1: a = BASE + 4 * $urandom_range(0, 15)
               + $urandom_range(1, 3);
        2: a = BASE - 4 * $urandom_range(1, 4);
        3: a = BASE + 4 * (DEPTH - 1 - $urandom_range(0, 1));
        default: a = BASE + 4 * $urandom_range(0, 15);
      endcase
      wd = $urandom;
      xfer(d, a, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), wd);
    end

    // Back-to-back on zero wait states.
    for (int i = 0; i < 4; i++)
      xfer(0, BASE + 32'(4 * i), 1'b1, 4'hF, $urandom);
    b2b(1'b0);
    b2b(1'b1);
    xfer(0, BASE + 8, 1'b0, 4'hF, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
